// File: rtl/matrix_dsp_pkg.sv
// Shared encodings for the self-sequencing matrix DSP unit: opcodes, instruction
// field positions, operand-B source encodings and sequencer states.
package matrix_dsp_pkg;

  localparam int INSTR_W  = 18;
  localparam int OP_LO    = 15;
  localparam int BSEL_LO  = 13;
  localparam int BADDR_LO = 9;
  localparam int ASEL_BIT = 8;
  localparam int AADDR_LO = 4;
  localparam int DST_LO   = 0;

  localparam logic [2:0] OP_END = 3'd7;

  typedef enum logic [1:0] {
    BSEL_VEC     = 2'd0,
    BSEL_MAT     = 2'd1,
    BSEL_ACC     = 2'd2,
    BSEL_ILLEGAL = 2'd3
  } bsel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    bsel_e      bSel;
    logic [3:0] bAddr;
    logic       aSel;
    logic [3:0] aAddr;
    logic [3:0] dst;
  } instr_t;

  function automatic instr_t decodeInstr(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.op    = w[OP_LO +: 3];
    d.bSel  = bsel_e'(w[BSEL_LO +: 2]);
    d.bAddr = w[BADDR_LO +: 4];
    d.aSel  = w[ASEL_BIT];
    d.aAddr = w[AADDR_LO +: 4];
    d.dst   = w[DST_LO +: 4];
    return d;
  endfunction

endpackage

// File: rtl/matrix_dsp_operand_mux.sv
// Combinational operand selector: vector lane, matrix lane or accumulator, with the
// in-flight FPU result substituted for any accumulator read that hits its destination.
module matrix_dsp_operand_mux
  import matrix_dsp_pkg::*;
#(
  parameter int ACC_DEPTH = 4
) (
  input  logic                         aSel,
  input  logic [3:0]                   aAddr,
  input  bsel_e                        bSel,
  input  logic [3:0]                   bAddr,
  input  logic [127:0]                 vector,
  input  logic [127:0]                 matrix,
  input  logic [31:0]                  acc [ACC_DEPTH],
  input  logic                         bypassEn,
  input  logic [$clog2(ACC_DEPTH)-1:0] bypassIdx,
  input  logic [31:0]                  bypassData,
  output logic [31:0]                  opA,
  output logic [31:0]                  opB
);

  localparam int AW = $clog2(ACC_DEPTH);

  logic [AW-1:0] aIdx, bIdx;
  logic [31:0]   aAcc, bAcc;
  logic          unusedAddrHi;

  // Lane 0 sits in the most significant word.
  function automatic logic [31:0] laneOf(input logic [127:0] row, input logic [1:0] idx);
    logic [31:0] r;
    case (idx)
      2'd0:    r = row[127:96];
      2'd1:    r = row[95:64];
      2'd2:    r = row[63:32];
      default: r = row[31:0];
    endcase
    return r;
  endfunction

  assign aIdx = aAddr[AW-1:0];
  assign bIdx = bAddr[AW-1:0];
  assign aAcc = (bypassEn && aIdx == bypassIdx) ? bypassData : acc[aIdx];
  assign bAcc = (bypassEn && bIdx == bypassIdx) ? bypassData : acc[bIdx];
  assign unusedAddrHi = ^{aAddr, bAddr};

  always_comb begin
    opA = aSel ? aAcc : laneOf(vector, aAddr[1:0]);
    opB = '0;
    case (bSel)
      BSEL_VEC: opB = laneOf(vector, bAddr[1:0]);
      BSEL_MAT: opB = laneOf(matrix, bAddr[1:0]);
      BSEL_ACC: opB = bAcc;
      default:  opB = '0;
    endcase
  end

endmodule

// File: rtl/matrix_dsp_sequencer.sv
// Self-sequencing matrix DSP unit: fetches microcode, issues FPU operations and
// retires results into an accumulator file, issuing the next op in the result cycle.
module matrix_dsp_sequencer
  import matrix_dsp_pkg::*;
#(
  parameter int ACC_DEPTH = 4,
  parameter int PC_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [PC_WIDTH-1:0]          start_pc,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [PC_WIDTH-1:0]          instr_addr,
  output logic                         instr_en,
  input  logic [INSTR_W-1:0]           instr_data,
  input  logic [127:0]                 vector,
  input  logic [127:0]                 matrix,
  output logic [1:0]                   matrix_sel,
  output logic                         fpu_start,
  output logic [2:0]                   fpu_op,
  output logic [31:0]                  fpu_a,
  output logic [31:0]                  fpu_b,
  input  logic                         fpu_done,
  input  logic [31:0]                  fpu_result,
  input  logic [$clog2(ACC_DEPTH)-1:0] acc_rd_addr,
  output logic [31:0]                  acc_rd_data,
  output logic [31:0]                  result
);

  localparam int AW = $clog2(ACC_DEPTH);

  state_e              state;
  logic [PC_WIDTH-1:0] pc, pcInc;
  logic [AW-1:0]       dstQ;
  logic                errQ;
  logic [31:0]         acc [ACC_DEPTH];
  logic [2:0]          opHold;
  logic [31:0]         aHold, bHold;
  instr_t              instr;
  logic                illegal, stop, resultValid, issue;
  logic [31:0]         opA, opB;
  logic                unusedDstHi;

  assign instr       = decodeInstr(instr_data);
  assign illegal     = (instr.bSel == BSEL_ILLEGAL);
  assign stop        = illegal || (instr.op == OP_END);
  assign resultValid = (state == S_WAIT) && fpu_done;
  // Issue is decided in the cycle the word (or the previous result) arrives, so it is not registered.
  assign issue       = !abort && !stop && ((state == S_ISSUE) || resultValid);
  assign pcInc       = pc + PC_WIDTH'(1);
  assign unusedDstHi = ^instr.dst;

  matrix_dsp_operand_mux #(.ACC_DEPTH(ACC_DEPTH)) uMux (
    .aSel       (instr.aSel),
    .aAddr      (instr.aAddr),
    .bSel       (instr.bSel),
    .bAddr      (instr.bAddr),
    .vector     (vector),
    .matrix     (matrix),
    .acc        (acc),
    .bypassEn   (resultValid),
    .bypassIdx  (dstQ),
    .bypassData (fpu_result),
    .opA        (opA),
    .opB        (opB)
  );

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign err         = errQ;
  assign instr_en    = (state == S_FETCH) || issue;
  assign instr_addr  = (state == S_ISSUE || state == S_WAIT) ? pcInc : pc;
  assign matrix_sel  = instr.bAddr[3:2];
  assign fpu_start   = issue;
  assign fpu_op      = issue ? instr.op : opHold;
  assign fpu_a       = issue ? opA : aHold;
  assign fpu_b       = issue ? opB : bHold;
  assign acc_rd_data = acc[acc_rd_addr];
  assign result      = acc[0];

  // Operands stay stable on the FPU bus between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opHold <= '0;
      aHold  <= '0;
      bHold  <= '0;
    end else if (issue) begin
      opHold <= instr.op;
      aHold  <= opA;
      bHold  <= opB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      dstQ  <= '0;
      errQ  <= 1'b0;
      for (int i = 0; i < ACC_DEPTH; i++) acc[i] <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= start_pc;
            errQ  <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_ISSUE;
        S_ISSUE: begin
          if (stop) begin
            errQ  <= errQ | illegal;
            state <= S_DONE;
          end else begin
            dstQ  <= instr.dst[AW-1:0];
            pc    <= pcInc;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fpu_done) begin
            acc[dstQ] <= fpu_result;
            if (stop) begin
              errQ  <= errQ | illegal;
              state <= S_DONE;
            end else begin
              dstQ <= instr.dst[AW-1:0];
              pc   <= pcInc;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_dsp_sequencer.sv
// Directed bench for matrix_dsp_sequencer with a latency-3 FPU model and a registered
// instruction memory; single-op programs are table driven, corner cases hand sequenced.
module tb_matrix_dsp_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   start_pc = '0;
  logic         abort = 1'b0;
  logic         busy, done, err, instr_en, fpu_start;
  logic [7:0]   instr_addr;
  logic [17:0]  instr_data = '0;
  logic [127:0] vector = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [127:0] matrix;
  logic [1:0]   matrix_sel;
  logic [2:0]   fpu_op;
  logic [31:0]  fpu_a, fpu_b, acc_rd_data, result;
  logic         fpu_done = 1'b0;
  logic [31:0]  fpu_result = '0;
  logic [1:0]   acc_rd_addr = '0;

  int applied = 0;
  int miscompares = 0;

  logic [17:0] imem [256];
  logic [17:0] END_W;
  int          lat = 0;
  logic [31:0] pendRes = '0;

  matrix_dsp_sequencer #(.ACC_DEPTH(4), .PC_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .abort(abort),
    .busy(busy), .done(done), .err(err), .instr_addr(instr_addr), .instr_en(instr_en),
    .instr_data(instr_data), .vector(vector), .matrix(matrix), .matrix_sel(matrix_sel),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .acc_rd_addr(acc_rd_addr),
    .acc_rd_data(acc_rd_data), .result(result)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (matrix_sel)
      2'd0:    matrix = {32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      2'd1:    matrix = {32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
      2'd2:    matrix = {32'h3F000000, 32'h3FC00000, 32'h40200000, 32'h40600000};
      default: matrix = {32'h41800000, 32'h42000000, 32'h42800000, 32'h43000000};
    endcase
  end

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpuCalc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    real x, y, z;
    x = f2r(a);
    y = f2r(b);
    case (op)
      3'd0:    z = x + y;
      3'd1:    z = x - y;
      3'd2:    z = x * y;
      default: z = x;
    endcase
    return r2f(z);
  endfunction

  // FPU model, latency 3: fpu_done is high three cycles after the fpu_start cycle.
  always @(posedge clk) begin
    fpu_done <= 1'b0;
    if (fpu_start) begin
      lat     <= 2;
      pendRes <= fpuCalc(fpu_op, fpu_a, fpu_b);
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1) begin
        fpu_done   <= 1'b1;
        fpu_result <= pendRes;
      end
    end
  end

  always @(posedge clk) begin
    if (instr_en) instr_data <= imem[instr_addr];
  end

  function automatic logic [17:0] mk(input int op, input int bsel, input int baddr,
                                     input int asel, input int aaddr, input int dst);
    return {3'(op), 2'(bsel), 4'(baddr), 1'(asel), 4'(aaddr), 4'(dst)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic pulseStart(input logic [7:0] pc0);
    start_pc = pc0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    tick();
  endtask

  task automatic chkAcc(input string tag, input int idx, input logic [31:0] exp);
    acc_rd_addr = 2'(idx);
    #1;
    chk($sformatf("%s acc%0d", tag, idx), acc_rd_data, exp);
  endtask

  typedef struct {
    logic [17:0] ins;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  msel;
    int          rd;
    logic [31:0] res;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sawDone;
    END_W = mk(7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) imem[i] = END_W;

    tbl[0] = '{mk(0, 0, 1,  0, 0, 0),  3'd0, 32'h3F800000, 32'h40000000, 2'd0, 0, 32'h40400000};
    tbl[1] = '{mk(2, 1, 3,  0, 2, 1),  3'd2, 32'h40400000, 32'h41000000, 2'd0, 1, 32'h41C00000};
    tbl[2] = '{mk(0, 1, 5,  1, 0, 2),  3'd0, 32'h40400000, 32'h41200000, 2'd1, 2, 32'h41500000};
    tbl[3] = '{mk(2, 2, 2,  1, 1, 3),  3'd2, 32'h41C00000, 32'h41500000, 2'd0, 3, 32'h439C0000};
    tbl[4] = '{mk(1, 1, 8,  0, 3, 0),  3'd1, 32'h40800000, 32'h3F000000, 2'd2, 0, 32'h40600000};
    tbl[5] = '{mk(0, 1, 14, 1, 3, 1),  3'd0, 32'h439C0000, 32'h42800000, 2'd3, 1, 32'h43BC0000};
    tbl[6] = '{mk(2, 0, 13, 1, 6, 14), 3'd2, 32'h41500000, 32'h40000000, 2'd3, 2, 32'h41D00000};

    // Reset state.
    tick();
    tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst instr_en", 32'(instr_en), 32'd0);
    chk("rst fpu_start", 32'(fpu_start), 32'd0);
    chk("rst fpu_a", fpu_a, 32'd0);
    chk("rst fpu_b", fpu_b, 32'd0);
    chk("rst fpu_op", 32'(fpu_op), 32'd0);
    chk("rst instr_addr", 32'(instr_addr), 32'd0);
    chk("rst result", result, 32'd0);
    reset = 1'b0;
    tick();

    // Single-op programs; accumulators carry over from one record to the next.
    for (int i = 0; i < 7; i++) begin
      imem[0] = tbl[i].ins;
      imem[1] = END_W;
      pulseStart(8'h00);
      tick();
      chk($sformatf("vec%0d fpu_start", i), 32'(fpu_start), 32'd1);
      chk($sformatf("vec%0d fpu_op", i), 32'(fpu_op), 32'(tbl[i].op));
      chk($sformatf("vec%0d fpu_a", i), fpu_a, tbl[i].a);
      chk($sformatf("vec%0d fpu_b", i), fpu_b, tbl[i].b);
      chk($sformatf("vec%0d matrix_sel", i), 32'(matrix_sel), 32'(tbl[i].msel));
      waitDone($sformatf("vec%0d", i));
      chkAcc($sformatf("vec%0d", i), tbl[i].rd, tbl[i].res);
    end

    // acc0 = v0 + v1 from 0x10, cycle-exact.
    imem[8'h10] = mk(0, 0, 1, 0, 0, 0);
    imem[8'h11] = END_W;
    pulseStart(8'h10);
    chk("seqA c1 instr_en", 32'(instr_en), 32'd1);
    chk("seqA c1 instr_addr", 32'(instr_addr), 32'h10);
    chk("seqA c1 busy", 32'(busy), 32'd1);
    tick();
    chk("seqA c2 fpu_start", 32'(fpu_start), 32'd1);
    chk("seqA c2 instr_en", 32'(instr_en), 32'd1);
    chk("seqA c2 instr_addr", 32'(instr_addr), 32'h11);
    chk("seqA c2 fpu_a", fpu_a, 32'h3F800000);
    chk("seqA c2 fpu_b", fpu_b, 32'h40000000);
    tick();
    chk("seqA c3 fpu_start", 32'(fpu_start), 32'd0);
    chk("seqA c3 instr_en", 32'(instr_en), 32'd0);
    tick();
    tick();
    chk("seqA c5 done", 32'(done), 32'd0);
    tick();
    chk("seqA c6 done", 32'(done), 32'd1);
    chk("seqA c6 result", result, 32'h40400000);
    tick();
    chk("seqA c7 done", 32'(done), 32'd0);
    chk("seqA c7 busy", 32'(busy), 32'd0);

    // Back-to-back chain through the bypass; acc1 holds a stale value beforehand.
    imem[8'h20] = mk(0, 0, 0, 0, 0, 1);
    imem[8'h21] = mk(2, 2, 1, 1, 1, 1);
    imem[8'h22] = END_W;
    pulseStart(8'h20);
    tick();
    chk("seqB c2 fpu_start", 32'(fpu_start), 32'd1);
    tick();
    tick();
    tick();
    chk("seqB c5 fpu_done", 32'(fpu_done), 32'd1);
    chk("seqB c5 fpu_start", 32'(fpu_start), 32'd1);
    chk("seqB c5 fpu_op", 32'(fpu_op), 32'd2);
    chk("seqB c5 fpu_a", fpu_a, 32'h40000000);
    chk("seqB c5 fpu_b", fpu_b, 32'h40000000);
    chk("seqB c5 instr_addr", 32'(instr_addr), 32'h22);
    waitDone("seqB");
    chkAcc("seqB", 1, 32'h40800000);

    // Illegal b_sel ends the program with err; the next start clears it.
    imem[8'h30] = mk(0, 3, 0, 0, 0, 0);
    pulseStart(8'h30);
    tick();
    chk("seqC c2 fpu_start", 32'(fpu_start), 32'd0);
    tick();
    chk("seqC c3 done", 32'(done), 32'd1);
    chk("seqC c3 err", 32'(err), 32'd1);
    tick();
    chk("seqC c4 busy", 32'(busy), 32'd0);
    chk("seqC c4 err", 32'(err), 32'd1);
    pulseStart(8'h10);
    chk("seqC restart err", 32'(err), 32'd0);
    waitDone("seqC restart");

    // Abort while the FPU op is in flight; its late result must be dropped.
    imem[8'h40] = mk(2, 1, 0, 0, 1, 0);
    imem[8'h41] = END_W;
    pulseStart(8'h40);
    tick();
    chk("seqD c2 fpu_start", 32'(fpu_start), 32'd1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("seqD c4 busy", 32'(busy), 32'd0);
    sawDone = done;
    tick();
    chk("seqD late fpu_done", 32'(fpu_done), 32'd1);
    chk("seqD late fpu_result", fpu_result, 32'h41200000);
    sawDone |= done;
    tick();
    sawDone |= done;
    tick();
    sawDone |= done;
    chk("seqD no done", 32'(sawDone), 32'd0);
    chkAcc("seqD", 0, 32'h40400000);
    chkAcc("seqD", 1, 32'h40800000);
    chkAcc("seqD", 2, 32'h41D00000);
    chkAcc("seqD", 3, 32'h439C0000);

    // Program counter wraps from 0xFF to 0x00.
    imem[8'hFF] = mk(0, 0, 3, 0, 2, 2);
    imem[8'h00] = mk(2, 0, 1, 0, 0, 3);
    imem[8'h01] = END_W;
    pulseStart(8'hFF);
    chk("seqE c1 instr_addr", 32'(instr_addr), 32'hFF);
    tick();
    chk("seqE c2 instr_addr", 32'(instr_addr), 32'h00);
    tick();
    tick();
    tick();
    chk("seqE c5 fpu_start", 32'(fpu_start), 32'd1);
    chk("seqE c5 instr_addr", 32'(instr_addr), 32'h01);
    chk("seqE c5 fpu_a", fpu_a, 32'h3F800000);
    waitDone("seqE");
    chkAcc("seqE", 2, 32'h40E00000);
    chkAcc("seqE", 3, 32'h40000000);

    // Asynchronous reset in WAIT takes effect between clock edges.
    pulseStart(8'h10);
    tick();
    tick();
    chk("seqF pre busy", 32'(busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("seqF busy", 32'(busy), 32'd0);
    chk("seqF result", result, 32'd0);
    #2;
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("seqF idle done", 32'(done), 32'd0);
    chkAcc("seqF", 1, 32'd0);
    chkAcc("seqF", 3, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
